lif_membrane: RTL and testbench

LIF_MEMBRANE -- requirements
Module: lif_membrane

---
 rtl/neuron_pkg.sv | 7 +
 rtl/lif_update.sv | 16 +
 rtl/lif_membrane.sv | 63 ++++++
 tb/tb_lif_membrane.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg: widths, saturation limit and state encoding shared by the LIF neuron blocks.
package neuron_pkg;
  localparam int IN_WIDTH = 11;
  localparam int V_WIDTH = 12;
  localparam logic [V_WIDTH-1:0] V_MAX = 12'd4095;
  typedef enum logic [1:0] {INTEGRATE, FIRE, REFRACT} state_t;
endpackage

// File: rtl/lif_update.sv
// lif_update: one timestep of leak plus input current, saturated to the membrane range.
module lif_update
  import neuron_pkg::*;
#(
  parameter int LEAK_SHIFT = 3
) (
  input  logic [V_WIDTH-1:0]  v_mem,
  input  logic [IN_WIDTH-1:0] in_current,
  output logic [V_WIDTH-1:0]  v_next
);
  logic [V_WIDTH:0] sum;
  always_comb begin
    sum = {1'b0, v_mem} - {1'b0, v_mem >> LEAK_SHIFT} + {2'b00, in_current};
    v_next = sum[V_WIDTH] ? V_MAX : sum[V_WIDTH-1:0];
  end
endmodule

// File: rtl/lif_membrane.sv
// lif_membrane: leaky integrate-and-fire neuron with refractory period and dropped-input counter.
module lif_membrane
  import neuron_pkg::*;
#(
  parameter logic [V_WIDTH-1:0] THRESH = 12'd1000,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [IN_WIDTH-1:0] in_current,
  output logic [V_WIDTH-1:0]  v_mem,
  output logic                spike,
  output logic                refractory,
  output logic [7:0]          drop_cnt
);
  localparam int CW = REFRAC_CYCLES > 1 ? $clog2(REFRAC_CYCLES + 1) : 1;
  state_t state_q, state_d;
  logic [V_WIDTH-1:0] v_q, v_d, v_next;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] drop_q, drop_d;
  logic fire;
  lif_update #(.LEAK_SHIFT(LEAK_SHIFT)) u_update (
    .v_mem(v_q),
    .in_current(in_current),
    .v_next(v_next)
  );
  always_comb begin
    state_d = state_q;
    v_d = v_q;
    cnt_d = cnt_q;
    drop_d = (in_valid && state_q != INTEGRATE && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    fire = v_next >= THRESH;
    if (state_q == INTEGRATE) begin
      v_d = in_valid ? (fire ? '0 : v_next) : v_q;
      state_d = (in_valid && fire) ? FIRE : INTEGRATE;
    end else if (state_q == FIRE) begin
      state_d = REFRAC_CYCLES == 0 ? INTEGRATE : REFRACT;
      cnt_d = CW'(REFRAC_CYCLES);
    end else begin
      cnt_d = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? INTEGRATE : REFRACT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INTEGRATE;
      v_q <= '0;
      cnt_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      v_q <= v_d;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
    end
  end
  assign v_mem = v_q;
  assign spike = state_q == FIRE;
  assign refractory = state_q != INTEGRATE;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_lif_membrane.sv
// tb_lif_membrane: five parameter variants driven in lockstep and checked against a timestep model.
module tb_lif_membrane;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [10:0] in_current = '0;
  logic [11:0] vm [5];
  logic sp [5];
  logic rf [5];
  logic [7:0] dc [5];
  int th [5] = '{1000, 4095, 1000, 0, 1000};
  int rc [5] = '{4, 4, 0, 4, 300};
  int mv [5];
  int mb [5];
  int md [5];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lif_membrane u0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_current(in_current),
                   .v_mem(vm[0]), .spike(sp[0]), .refractory(rf[0]), .drop_cnt(dc[0]));
  lif_membrane #(.THRESH(12'd4095)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_current(in_current),
                   .v_mem(vm[1]), .spike(sp[1]), .refractory(rf[1]), .drop_cnt(dc[1]));
  lif_membrane #(.REFRAC_CYCLES(0)) u2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_current(in_current),
                   .v_mem(vm[2]), .spike(sp[2]), .refractory(rf[2]), .drop_cnt(dc[2]));
  lif_membrane #(.THRESH(12'd0)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_current(in_current),
                   .v_mem(vm[3]), .spike(sp[3]), .refractory(rf[3]), .drop_cnt(dc[3]));
  lif_membrane #(.REFRAC_CYCLES(300)) u4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_current(in_current),
                   .v_mem(vm[4]), .spike(sp[4]), .refractory(rf[4]), .drop_cnt(dc[4]));

  // Model: mb counts the non-integrating cycles still ahead (FIRE plus refractory).
  task automatic step(input logic r, input logic iv, input logic [10:0] ic);
    int n;
    @(negedge clk);
    rst = r;
    in_valid = iv;
    in_current = ic;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      if (r) begin
        mv[k] = 0;
        mb[k] = 0;
        md[k] = 0;
      end else if (mb[k] > 0) begin
        mb[k]--;
        if (iv && md[k] < 255) md[k]++;
      end else if (iv) begin
        n = mv[k] - mv[k] / 8 + int'(ic);
        if (n > 4095) n = 4095;
        if (n >= th[k]) begin
          mv[k] = 0;
          mb[k] = 1 + rc[k];
        end else mv[k] = n;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 11'd500);
    step(1'b1, 1'b1, 11'd500);
    for (int k = 0; k < 5; k++) begin
      vectors += 4;
      if (vm[k] !== 12'd0) begin miscompares++; $display("FAIL reset_vmem[%0d] got %0d want 0", k, vm[k]); end
      if (sp[k] !== 1'b0) begin miscompares++; $display("FAIL reset_spike[%0d] got %b want 0", k, sp[k]); end
      if (rf[k] !== 1'b0) begin miscompares++; $display("FAIL reset_refr[%0d] got %b want 0", k, rf[k]); end
      if (dc[k] !== 8'd0) begin miscompares++; $display("FAIL reset_drop[%0d] got %0d want 0", k, dc[k]); end
    end
  endtask

  task automatic test_leak_chain();
    int exp_v [3] = '{400, 750, 0};
    step(1'b0, 1'b0, 11'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 11'd400);
      vectors += 2;
      if (vm[0] !== 12'(exp_v[i])) begin miscompares++; $display("FAIL leak_vmem step %0d got %0d want %0d", i, vm[0], exp_v[i]); end
      if (sp[0] !== (i == 2)) begin miscompares++; $display("FAIL leak_spike step %0d got %b want %b", i, sp[0], i == 2); end
    end
    repeat (6) step(1'b0, 1'b0, 11'd0);
  endtask

  task automatic test_direct_fire();
    int r0 = 0, s0 = 0, r2 = 0;
    step(1'b1, 1'b0, 11'd0);
    step(1'b0, 1'b1, 11'd1200);
    for (int i = 0; i < 8; i++) begin
      if (rf[0]) r0++;
      if (sp[0]) s0++;
      if (rf[2]) r2++;
      step(1'b0, 1'b0, 11'd0);
    end
    vectors += 4;
    if (r0 != 5) begin miscompares++; $display("FAIL fire_refr_len got %0d want 5", r0); end
    if (s0 != 1) begin miscompares++; $display("FAIL fire_spike_len got %0d want 1", s0); end
    if (r2 != 1) begin miscompares++; $display("FAIL fire_refr0_len got %0d want 1", r2); end
    if (rf[0] !== 1'b0) begin miscompares++; $display("FAIL fire_back_integrate got %b want 0", rf[0]); end
  endtask

  task automatic test_drops();
    step(1'b1, 1'b0, 11'd0);
    step(1'b0, 1'b1, 11'd1200);
    repeat (3) step(1'b0, 1'b1, 11'd100);
    repeat (2) step(1'b0, 1'b0, 11'd0);
    vectors += 3;
    if (dc[0] !== 8'd3) begin miscompares++; $display("FAIL drops_cnt got %0d want 3", dc[0]); end
    if (vm[0] !== 12'd0) begin miscompares++; $display("FAIL drops_vmem got %0d want 0", vm[0]); end
    if (rf[0] !== 1'b0) begin miscompares++; $display("FAIL drops_refr_end got %b want 0", rf[0]); end
    step(1'b0, 1'b1, 11'd300);
    vectors += 2;
    if (vm[0] !== 12'd300) begin miscompares++; $display("FAIL drops_first_integrate got %0d want 300", vm[0]); end
    if (dc[0] !== 8'd3) begin miscompares++; $display("FAIL drops_cnt_hold got %0d want 3", dc[0]); end
  endtask

  task automatic test_saturation();
    int exp_v [3] = '{2047, 3839, 0};
    step(1'b1, 1'b0, 11'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 11'd2047);
      vectors += 2;
      if (vm[1] !== 12'(exp_v[i])) begin miscompares++; $display("FAIL sat_vmem step %0d got %0d want %0d", i, vm[1], exp_v[i]); end
      if (sp[1] !== (i == 2)) begin miscompares++; $display("FAIL sat_spike step %0d got %b want %b", i, sp[1], i == 2); end
    end
  endtask

  task automatic test_reset_mid_refract();
    int bad = 0;
    step(1'b1, 1'b0, 11'd0);
    step(1'b0, 1'b1, 11'd1200);
    step(1'b0, 1'b0, 11'd0);
    step(1'b0, 1'b0, 11'd0);
    vectors++;
    if (rf[0] !== 1'b1) begin miscompares++; $display("FAIL abort_pre_refr got %b want 1", rf[0]); end
    step(1'b1, 1'b0, 11'd0);
    vectors += 2;
    if (rf[0] !== 1'b0) begin miscompares++; $display("FAIL abort_refr got %b want 0", rf[0]); end
    if (sp[0] !== 1'b0) begin miscompares++; $display("FAIL abort_spike got %b want 0", sp[0]); end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 11'd0);
      if (sp[0] || rf[0]) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL abort_residual got %0d busy cycles want 0", bad); end
  endtask

  task automatic test_thresh_zero();
    step(1'b1, 1'b0, 11'd0);
    step(1'b0, 1'b1, 11'd0);
    vectors += 3;
    if (sp[3] !== 1'b1) begin miscompares++; $display("FAIL thr0_spike got %b want 1", sp[3]); end
    if (vm[3] !== 12'd0) begin miscompares++; $display("FAIL thr0_vmem got %0d want 0", vm[3]); end
    if (sp[0] !== 1'b0) begin miscompares++; $display("FAIL thr0_default_spike got %b want 0", sp[0]); end
  endtask

  task automatic test_drop_saturate();
    step(1'b1, 1'b0, 11'd0);
    step(1'b0, 1'b1, 11'd1200);
    repeat (299) step(1'b0, 1'b1, 11'd5);
    vectors += 2;
    if (dc[4] !== 8'd255) begin miscompares++; $display("FAIL drop_sat got %0d want 255", dc[4]); end
    if (rf[4] !== 1'b1) begin miscompares++; $display("FAIL drop_sat_refr got %b want 1", rf[4]); end
  endtask

  task automatic test_random();
    step(1'b1, 1'b0, 11'd0);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99) < 2, $urandom_range(1), 11'($urandom_range(2047)));
      for (int k = 0; k < 5; k++) begin
        vectors += 4;
        if (vm[k] !== 12'(mv[k])) begin miscompares++; $display("FAIL rand_vmem[%0d] cyc %0d got %0d want %0d", k, i, vm[k], mv[k]); end
        if (sp[k] !== (mb[k] == rc[k] + 1)) begin miscompares++; $display("FAIL rand_spike[%0d] cyc %0d got %b want %b", k, i, sp[k], mb[k] == rc[k] + 1); end
        if (rf[k] !== (mb[k] > 0)) begin miscompares++; $display("FAIL rand_refr[%0d] cyc %0d got %b want %b", k, i, rf[k], mb[k] > 0); end
        if (dc[k] !== 8'(md[k])) begin miscompares++; $display("FAIL rand_drop[%0d] cyc %0d got %0d want %0d", k, i, dc[k], md[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_leak_chain();
    test_direct_fire();
    test_drops();
    test_saturation();
    test_reset_mid_refract();
    test_thresh_zero();
    test_drop_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
